// File: rtl/sum_parallel_lanes.sv
// Streaming group summer: samples go round-robin into LANES accumulators.
// Each completed group of GROUP_LEN samples yields one registered sum.
module sum_parallel_lanes #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned GROUP_LEN = 128,
    parameter bit          SIGNED    = 1'b0,
    localparam int unsigned SUM_W    = DATA_W + $clog2(GROUP_LEN)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              data_start,
    output logic [SUM_W-1:0]  sum,
    output logic              sum_valid,
    output logic              busy,
    output logic              err_restart
);

    localparam int unsigned CNT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_LEN - 1);
    localparam logic [LANES-1:0] LANE0 = LANES'(1);

    typedef enum logic {StIdle, StAcc} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LANES-1:0]   ptr_q, ptr_d;
    logic [SUM_W-1:0]   lane_q [LANES];
    logic [SUM_W-1:0]   lane_d [LANES];
    logic               done_q, done_d;
    logic               err_d;
    logic [SUM_W-1:0]   ext_data;
    logic [SUM_W-1:0]   lane_total;

    function automatic logic [LANES-1:0] rotate(input logic [LANES-1:0] p);
        logic [LANES-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i] = p[(i + LANES - 1) % LANES];
        end
        return r;
    endfunction

    assign ext_data = SIGNED ? SUM_W'($signed(in_data)) : SUM_W'(in_data);
    assign busy     = (state_q == StAcc);

    always_comb begin
        lane_total = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_total = lane_total + lane_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (in_valid && data_start) begin
            // A start while a group is open aborts it without a result.
            err_d = (state_q == StAcc);
            for (int i = 0; i < LANES; i++) begin
                lane_d[i] = '0;
            end
            lane_d[0] = ext_data;
            if (GROUP_LEN == 1) begin
                state_d = StIdle;
                count_d = '0;
                ptr_d   = LANE0;
                done_d  = 1'b1;
            end else begin
                state_d = StAcc;
                count_d = CNT_W'(1);
                ptr_d   = rotate(LANE0);
            end
        end else if (state_q == StAcc && in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (ptr_q[i]) begin
                    lane_d[i] = lane_q[i] + ext_data;
                end
            end
            if (count_q == LAST_CNT) begin
                state_d = StIdle;
                count_d = '0;
                ptr_d   = LANE0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
                ptr_d   = rotate(ptr_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            count_q     <= '0;
            ptr_q       <= LANE0;
            done_q      <= 1'b0;
            err_restart <= 1'b0;
            sum_valid   <= 1'b0;
            sum         <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            err_restart <= err_d;
            sum_valid   <= done_q;
            // Reads the pre-reload lanes, so a back-to-back start is safe.
            if (done_q) begin
                sum <= lane_total;
            end
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

endmodule
